can_filter_sched: RTL and testbench

//  Shares one CAN-ID acceptance comparator between NUM_CH receive channels.

---
 rtl/can_gw_pkg.sv | 23 ++
 rtl/can_rr_arbiter.sv | 29 ++
 rtl/can_filter_sched.sv | 165 ++++++++++++++++
 tb/tb_can_filter_sched.sv | 384 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/can_gw_pkg.sv
// Shared types for the CAN gateway acceptance-filter path: ID width, filter table entry, scheduler states.
package can_gw_pkg;

    localparam int CAN_ID_W = 11;

    typedef struct packed {
        logic [CAN_ID_W-1:0] code;
        logic [CAN_ID_W-1:0] mask;
        logic                en;
    } filt_entry_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        OUT  = 2'd2
    } sched_state_e;

    // Mask bit set means that ID bit must equal the code bit; disabled entries never match.
    function automatic logic id_match(input filt_entry_t e, input logic [CAN_ID_W-1:0] id);
        return e.en && ((id & e.mask) == (e.code & e.mask));
    endfunction

endpackage

// File: rtl/can_rr_arbiter.sv
// Round-robin request picker: first requester strictly after ptr, searching upward with wrap.
module can_rr_arbiter #(
    parameter  int NUM_CH = 4,
    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    output logic [NUM_CH-1:0] grant,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        // i runs 1..NUM_CH so the pointer channel itself is visited last.
        for (int i = 1; i <= NUM_CH; i++) begin
            logic [CH_W-1:0] cand;
            cand = CH_W'((int'(ptr) + i) % NUM_CH);
            if (!any && req[cand]) begin
                any         = 1'b1;
                idx         = cand;
                grant[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/can_filter_sched.sv
// Shares one CAN-ID acceptance comparator across NUM_CH RX channels, walking the filter table one entry per cycle.
// Optional hit/drop statistics counters are built when CAN_FILTER_STATS_EN is defined.
//
//  state | meaning
//  IDLE  | waiting for any in_valid; grants one channel round-robin
//  SCAN  | comparing latched ID against table entry idx
//  OUT   | accepted ID presented on out_*, waiting for out_ready
module can_filter_sched
    import can_gw_pkg::*;
#(
    parameter  int NUM_CH      = 4,
    parameter  int NUM_FILTERS = 8,
    parameter  int CNT_W       = 16,
    localparam int IDX_W       = $clog2(NUM_FILTERS),
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_CH-1:0]          in_valid,
    input  logic [NUM_CH*CAN_ID_W-1:0] in_id,
    output logic [NUM_CH-1:0]          in_ready,
    input  logic                       cfg_we,
    input  logic [IDX_W-1:0]           cfg_idx,
    input  logic [CAN_ID_W-1:0]        cfg_code,
    input  logic [CAN_ID_W-1:0]        cfg_mask,
    input  logic                       cfg_en,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CAN_ID_W-1:0]        out_id,
    output logic [CH_W-1:0]            out_ch,
    output logic [IDX_W-1:0]           out_filt,
    output logic                       miss_pulse,
    output logic                       busy
`ifdef CAN_FILTER_STATS_EN
    ,
    input  logic [IDX_W-1:0]           stat_idx,
    output logic [CNT_W-1:0]           stat_hits,
    output logic [CNT_W-1:0]           stat_drops
`endif
);

    sched_state_e       state, state_nx;
    filt_entry_t        filt_tbl [NUM_FILTERS];
    logic [CH_W-1:0]    rr_ptr;
    logic [IDX_W-1:0]   idx;
    logic [NUM_CH-1:0]  arb_grant;
    logic [CH_W-1:0]    arb_idx;
    logic               arb_any;
    logic               hit;
    logic               last;

    can_rr_arbiter #(.NUM_CH(NUM_CH)) u_arb (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (arb_grant),
        .idx   (arb_idx),
        .any   (arb_any)
    );

    // out_id doubles as the latched ID under comparison, so the table reads the registered value.
    assign hit       = id_match(filt_tbl[idx], out_id);
    assign last      = (idx == IDX_W'(NUM_FILTERS - 1));
    assign out_valid = (state == OUT);
    assign busy      = (state != IDLE);

    always_comb begin
        state_nx = state;
        in_ready = '0;
        unique case (state)
            IDLE: begin
                if (arb_any) begin
                    in_ready = arb_grant;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (hit) begin
                    state_nx = OUT;
                end else if (last) begin
                    state_nx = IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            rr_ptr     <= CH_W'(NUM_CH - 1);
            idx        <= '0;
            out_id     <= '0;
            out_ch     <= '0;
            out_filt   <= '0;
            miss_pulse <= 1'b0;
        end else begin
            state      <= state_nx;
            miss_pulse <= (state == SCAN) && !hit && last;
            unique case (state)
                IDLE: begin
                    if (arb_any) begin
                        out_id <= in_id[arb_idx*CAN_ID_W +: CAN_ID_W];
                        out_ch <= arb_idx;
                        rr_ptr <= arb_idx;
                        idx    <= '0;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        out_filt <= idx;
                    end else if (!last) begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Table writes land at the clock edge, so a same-cycle comparison still sees the old entry.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_FILTERS; k++) begin
                filt_tbl[k] <= '0;
            end
        end else if (cfg_we && (int'(cfg_idx) < NUM_FILTERS)) begin
            filt_tbl[cfg_idx] <= '{code: cfg_code, mask: cfg_mask, en: cfg_en};
        end
    end

`ifdef CAN_FILTER_STATS_EN
    logic [CNT_W-1:0] hit_cnt [NUM_FILTERS];
    logic [CNT_W-1:0] drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_FILTERS; k++) begin
                hit_cnt[k] <= '0;
            end
            drop_cnt <= '0;
        end else if (state == SCAN) begin
            if (hit) begin
                if (hit_cnt[idx] != '1) begin
                    hit_cnt[idx] <= hit_cnt[idx] + 1'b1;
                end
            end else if (last && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign stat_hits  = (int'(stat_idx) < NUM_FILTERS) ? hit_cnt[stat_idx] : '0;
    assign stat_drops = drop_cnt;
`else
    // CNT_W only sizes the statistics counters.
    logic cnt_w_unused;
    assign cnt_w_unused = CNT_W[0];
`endif

endmodule

// File: tb/tb_can_filter_sched.sv
// Randomized self-checking bench for can_filter_sched against a transaction-level acceptance model.
module tb_can_filter_sched;
    import can_gw_pkg::*;

    localparam int NCH  = 4;
    localparam int NF   = 8;
    localparam int NF_B = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NCH-1:0]    in_valid, in_ready;
    logic [NCH*11-1:0] in_id;
    logic              cfg_we, cfg_en;
    logic [2:0]        cfg_idx;
    logic [10:0]       cfg_code, cfg_mask;
    logic              out_valid, out_ready, miss_pulse, busy;
    logic [10:0]       out_id;
    logic [1:0]        out_ch;
    logic [2:0]        out_filt;

    logic [1:0]        b_in_valid, b_in_ready;
    logic [21:0]       b_in_id;
    logic              b_cfg_we, b_cfg_en;
    logic [2:0]        b_cfg_idx;
    logic [10:0]       b_cfg_code, b_cfg_mask;
    logic              b_out_valid, b_miss_pulse, b_busy;
    logic [10:0]       b_out_id;
    logic [0:0]        b_out_ch;
    logic [2:0]        b_out_filt;
`ifdef CAN_FILTER_STATS_EN
    logic [2:0]  stat_idx = 3'd0, b_stat_idx = 3'd0;
    logic [15:0] stat_hits, stat_drops, b_stat_hits, b_stat_drops;
`endif

    can_filter_sched #(.NUM_CH(NCH), .NUM_FILTERS(NF), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_id(in_id), .in_ready(in_ready),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_code(cfg_code), .cfg_mask(cfg_mask), .cfg_en(cfg_en),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_ch(out_ch),
        .out_filt(out_filt), .miss_pulse(miss_pulse), .busy(busy)
`ifdef CAN_FILTER_STATS_EN
        , .stat_idx(stat_idx), .stat_hits(stat_hits), .stat_drops(stat_drops)
`endif
    );

    can_filter_sched #(.NUM_CH(2), .NUM_FILTERS(NF_B), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_id(b_in_id), .in_ready(b_in_ready),
        .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx), .cfg_code(b_cfg_code), .cfg_mask(b_cfg_mask), .cfg_en(b_cfg_en),
        .out_valid(b_out_valid), .out_ready(1'b1), .out_id(b_out_id), .out_ch(b_out_ch),
        .out_filt(b_out_filt), .miss_pulse(b_miss_pulse), .busy(b_busy)
`ifdef CAN_FILTER_STATS_EN
        , .stat_idx(b_stat_idx), .stat_hits(b_stat_hits), .stat_drops(b_stat_drops)
`endif
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference state: the acceptance table and the last granted channel.
    logic [10:0] m_code [NF];
    logic [10:0] m_mask [NF];
    logic        m_en   [NF];
    int          rr_ptr;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int k = 0; k < NF; k++) begin
            m_code[k] = '0;
            m_mask[k] = '0;
            m_en[k]   = 1'b0;
        end
        rr_ptr = NCH - 1;
    endfunction

    function automatic int model_grant(input logic [NCH-1:0] v, input int p);
        for (int i = 1; i <= NCH; i++) begin
            int c;
            c = (p + i) % NCH;
            if (v[c]) return c;
        end
        return -1;
    endfunction

    // A write issued wr_at cycles after the grant is visible to entries compared later (entry k at cycle 1+k).
    function automatic int model_match(input logic [10:0] id, input int wr_at, input int wr_idx,
                                       input logic [10:0] wc, input logic [10:0] wm, input logic wen);
        for (int k = 0; k < NF; k++) begin
            logic [10:0] c, m;
            logic        e;
            c = m_code[k];
            m = m_mask[k];
            e = m_en[k];
            if (wr_at > 0 && k == wr_idx && k >= wr_at) begin
                c = wc;
                m = wm;
                e = wen;
            end
            if (e && (((id ^ c) & m) == 11'h0)) return k;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic cfg_write(input int idx, input logic [10:0] code, input logic [10:0] mask, input logic en);
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_code = code; cfg_mask = mask; cfg_en = en;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        m_code[idx] = code; m_mask[idx] = mask; m_en[idx] = en;
    endtask

    task automatic transact(input logic [NCH-1:0] vld, input logic [NCH*11-1:0] ids, input int hold,
                            input int wr_at, input int wr_idx, input logic [10:0] wc,
                            input logic [10:0] wm, input logic wen);
        int g, f, ev;
        logic [10:0] id;
        @(posedge clk); #1;
        in_valid = vld;
        in_id    = ids;
        g = model_grant(vld, rr_ptr);
        @(negedge clk);
        chk("grant", 32'(in_ready), 32'(1) << g);
        chk("busy_idle", 32'(busy), 0);
        @(posedge clk); #1;
        in_valid = '0;
        rr_ptr = g;
        id = ids[g*11 +: 11];
        f  = model_match(id, wr_at, wr_idx, wc, wm, wen);
        ev = (f >= 0) ? 2 + f : NF + 1;
        for (int n = 1; n <= ev; n++) begin
            if (n > 1) begin
                @(posedge clk); #1;
            end
            cfg_we = (n == wr_at);
            if (n == wr_at) begin
                cfg_idx = 3'(wr_idx); cfg_code = wc; cfg_mask = wm; cfg_en = wen;
            end
            @(negedge clk);
            if (n < ev) begin
                chk("scan_no_out", 32'(out_valid), 0);
                chk("scan_no_miss", 32'(miss_pulse), 0);
                chk("scan_in_ready", 32'(in_ready), 0);
                chk("scan_busy", 32'(busy), 1);
            end
        end
        if (wr_at > 0) begin
            m_code[wr_idx] = wc; m_mask[wr_idx] = wm; m_en[wr_idx] = wen;
        end
        if (f >= 0) begin
            chk("out_valid_rise", 32'(out_valid), 1);
            chk("out_miss_low", 32'(miss_pulse), 0);
            for (int h = 0; h <= hold; h++) begin
                @(posedge clk); #1;
                cfg_we    = 1'b0;
                out_ready = (h == hold);
                in_valid  = (h < hold) ? vld : '0;
                @(negedge clk);
                chk("out_valid_hold", 32'(out_valid), 1);
                chk("out_id", 32'(out_id), 32'(id));
                chk("out_ch", 32'(out_ch), 32'(g));
                chk("out_filt", 32'(out_filt), 32'(f));
                chk("out_in_ready", 32'(in_ready), 0);
            end
            @(posedge clk); #1;
            out_ready = 1'b0;
            @(negedge clk);
            chk("out_valid_fall", 32'(out_valid), 0);
            chk("busy_after_out", 32'(busy), 0);
        end else begin
            chk("miss_pulse", 32'(miss_pulse), 1);
            chk("miss_no_out", 32'(out_valid), 0);
            chk("miss_busy", 32'(busy), 0);
            @(posedge clk); #1;
            cfg_we = 1'b0;
            @(negedge clk);
            chk("miss_pulse_1cyc", 32'(miss_pulse), 0);
        end
    endtask

    function automatic logic [NCH*11-1:0] rand_ids();
        logic [NCH*11-1:0] v;
        for (int c = 0; c < NCH; c++) begin
            if ($urandom_range(0, 1) == 1) begin
                v[c*11 +: 11] = m_code[$urandom_range(0, NF-1)] ^ 11'($urandom_range(0, 3));
            end else begin
                v[c*11 +: 11] = 11'($urandom);
            end
        end
        return v;
    endfunction

    function automatic logic [10:0] rand_mask();
        case ($urandom_range(0, 4))
            0: return 11'h7FF;
            1: return 11'h700;
            2: return 11'h7F0;
            3: return 11'h000;
            default: return 11'($urandom);
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NCH*11-1:0] ids;
        int grants, cyc, seen_out, seen_miss, got_filt, got_ch;
        rst = 1'b0;
        in_valid = '0; in_id = '0; out_ready = 1'b0;
        cfg_we = 1'b0; cfg_idx = '0; cfg_code = '0; cfg_mask = '0; cfg_en = 1'b0;
        b_in_valid = '0; b_in_id = '0;
        b_cfg_we = 1'b0; b_cfg_idx = '0; b_cfg_code = '0; b_cfg_mask = '0; b_cfg_en = 1'b0;
        model_clear();
        do_reset();

        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 0);
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_id", 32'(out_id), 0);
        chk("rst_out_ch", 32'(out_ch), 0);
        chk("rst_out_filt", 32'(out_filt), 0);
        chk("rst_miss", 32'(miss_pulse), 0);
        chk("rst_busy", 32'(busy), 0);

        // Coarse match on entry 0; ch0 wins first after reset.
        cfg_write(0, 11'h100, 11'h700, 1'b1);
        transact(4'b0001, {33'h0, 11'h123}, 0, 0, 0, '0, '0, 1'b0);

        // Only entry 5, exact match: hit late, then a full-table miss.
        do_reset();
        cfg_write(5, 11'h7FF, 11'h7FF, 1'b1);
        transact(4'b0001, {33'h0, 11'h7FF}, 0, 0, 0, '0, '0, 1'b0);
        transact(4'b0010, {22'h0, 11'h7FE, 11'h0}, 0, 0, 0, '0, '0, 1'b0);

        // Downstream backpressure for 5 cycles with other channels still requesting.
        transact(4'b1111, {11'h7FF, 11'h7FF, 11'h7FF, 11'h7FF}, 5, 0, 0, '0, '0, 1'b0);

        // Rewrite entry 1 during the cycle it is compared.
        do_reset();
        cfg_write(1, 11'h0AA, 11'h7FF, 1'b1);
        transact(4'b0001, {33'h0, 11'h0AA}, 0, 2, 1, 11'h055, 11'h7FF, 1'b1);
        transact(4'b0001, {33'h0, 11'h0AA}, 0, 0, 0, '0, '0, 1'b0);
        transact(4'b0001, {33'h0, 11'h055}, 0, 0, 0, '0, '0, 1'b0);

        // All channels valid continuously: strict rotation.
        cfg_write(0, 11'h000, 11'h000, 1'b1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        in_valid  = 4'b1111;
        in_id     = rand_ids();
        grants = 0;
        cyc    = 0;
        while (grants < 5 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (in_ready != '0) begin
                int gi, e;
                gi = 0;
                for (int c = 0; c < NCH; c++) if (in_ready[c]) gi = c;
                e = (rr_ptr + 1) % NCH;
                chk("rr_onehot", 32'($onehot(in_ready)), 1);
                chk("rr_order", 32'(gi), 32'(e));
                rr_ptr = e;
                grants++;
            end
        end
        chk("rr_grant_count", 32'(grants), 5);
        @(posedge clk); #1;
        in_valid = '0;
        repeat (NF + 4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("rr_drain_busy", 32'(busy), 0);

        // Out-of-range table index on a 6-entry instance is ignored.
        @(posedge clk); #1;
        b_cfg_we = 1'b1; b_cfg_idx = 3'd6; b_cfg_code = '0; b_cfg_mask = '0; b_cfg_en = 1'b1;
        @(posedge clk); #1;
        b_cfg_idx = 3'd7;
        @(posedge clk); #1;
        b_cfg_we = 1'b0;
        b_in_valid = 2'b01; b_in_id = {11'h0, 11'h055};
        @(negedge clk);
        chk("b_grant", 32'(b_in_ready), 1);
        @(posedge clk); #1;
        b_in_valid = '0;
        seen_out = 0; seen_miss = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (b_out_valid) seen_out++;
            if (b_miss_pulse) seen_miss++;
        end
        chk("b_ignored_no_out", 32'(seen_out), 0);
        chk("b_ignored_miss", 32'(seen_miss), 1);
        @(posedge clk); #1;
        b_cfg_we = 1'b1; b_cfg_idx = 3'd5; b_cfg_code = '0; b_cfg_mask = '0; b_cfg_en = 1'b1;
        @(posedge clk); #1;
        b_cfg_we = 1'b0;
        b_in_valid = 2'b10; b_in_id = {11'h321, 11'h0};
        @(posedge clk); #1;
        b_in_valid = '0;
        seen_out = 0; got_filt = 0; got_ch = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (b_out_valid) begin
                seen_out++;
                got_filt = int'(b_out_filt);
                got_ch   = int'(b_out_ch);
            end
        end
        chk("b_last_hit_seen", 32'(seen_out), 1);
        chk("b_last_hit_filt", 32'(got_filt), 5);
        chk("b_last_hit_ch", 32'(got_ch), 1);

        // Randomized traffic, table updates and backpressure.
        do_reset();
        for (int k = 0; k < NF; k++) begin
            cfg_write(k, 11'($urandom), rand_mask(), 1'($urandom_range(0, 1)));
        end
        for (int r = 0; r < 40; r++) begin
            logic [NCH-1:0] v;
            int wa;
            if ($urandom_range(0, 3) == 0) begin
                cfg_write($urandom_range(0, NF-1), 11'($urandom), rand_mask(), 1'($urandom_range(0, 1)));
            end
            v  = NCH'($urandom_range(1, (1 << NCH) - 1));
            wa = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0;
            transact(v, rand_ids(), $urandom_range(0, 3), wa, $urandom_range(0, NF-1),
                     11'($urandom), rand_mask(), 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a scan discards the transaction and clears the table.
        do_reset();
        cfg_write(7, 11'h000, 11'h000, 1'b1);
        @(posedge clk); #1;
        in_valid = 4'b0100;
        in_id    = {11'h0, 11'h2A5, 22'h0};
        @(posedge clk); #1;
        in_valid = '0;
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            chk("rst_mid_out", 32'(out_valid), 0);
            chk("rst_mid_miss", 32'(miss_pulse), 0);
            chk("rst_mid_busy", 32'(busy), 0);
        end
        rst = 1'b0;
        model_clear();
        seen_out = 0; seen_miss = 0;
        for (int n = 0; n < 12; n++) begin
            @(negedge clk);
            if (out_valid) seen_out++;
            if (miss_pulse) seen_miss++;
        end
        chk("rst_after_out", 32'(seen_out), 0);
        chk("rst_after_miss", 32'(seen_miss), 0);
        transact(4'b0100, {11'h0, 11'h2A5, 22'h0}, 0, 0, 0, '0, '0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
